uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 195 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Buffered asynchronous serial transmitter. Words are accepted over
//            a valid/ready handshake into a circular FIFO. Each word is sent
//            as start bit, DATA_BITS data bits (LSB first), an optional
//            even/odd parity bit and STOP_BITS stop bits. Bit timing comes
//            from an internal clock divider.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 3
) (
  input  logic                 Clock,
  input  logic                 reset_,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [1:0]           parity_mode,
  output logic                 Serial_out,
  output logic                 busy,
  output logic [CNT_W-1:0]     fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int DIV_W = $clog2(CLKS_PER_BIT);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // FIFO storage and pointers
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [DATA_BITS-1:0] head;

  // Serialiser state
  state_t               state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [3:0]           bit_idx;
  logic [DIV_W-1:0]     div_cnt;
  logic                 par_en;
  logic                 par_bit;

  logic push;
  logic pop;
  logic div_last;
  logic stop_done;

  assign head      = mem[rd_ptr];
  assign tx_ready  = (fifo_count != CNT_FULL);
  assign push      = tx_valid && tx_ready;
  assign div_last  = (div_cnt == DIV_LAST);
  // Last cycle of the final stop bit: the slot where a queued word can be
  // popped so the next start bit follows without an idle cycle.
  assign stop_done = (state == STOP) && div_last && (bit_idx == STOP_LAST);
  assign pop       = (fifo_count != '0) && ((state == IDLE) || stop_done);
  assign busy      = (state != IDLE);

  // FIFO storage write; contents need no reset because the count gates reads
  always_ff @(posedge Clock) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop keeps the count
  always_ff @(posedge Clock) begin
    if (reset_) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Frame sequencer: the state walks the frame and Serial_out is registered
  // one bit ahead, so each slot lasts exactly CLKS_PER_BIT cycles
  always_ff @(posedge Clock) begin
    if (reset_) begin
      state      <= IDLE;
      Serial_out <= 1'b1;
      shift_reg  <= '0;
      bit_idx    <= '0;
      div_cnt    <= '0;
      par_en     <= 1'b0;
      par_bit    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Serial_out <= 1'b1;
        end
        START: begin
          if (div_last) begin
            div_cnt    <= '0;
            bit_idx    <= '0;
            Serial_out <= shift_reg[0];
            state      <= DATA;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DATA: begin
          if (div_last) begin
            div_cnt <= '0;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              if (par_en) begin
                Serial_out <= par_bit;
                state      <= PARITY;
              end else begin
                Serial_out <= 1'b1;
                state      <= STOP;
              end
            end else begin
              shift_reg  <= shift_reg >> 1;
              Serial_out <= shift_reg[1];
              bit_idx    <= bit_idx + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (div_last) begin
            div_cnt    <= '0;
            bit_idx    <= '0;
            Serial_out <= 1'b1;
            state      <= STOP;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        STOP: begin
          if (div_last) begin
            div_cnt <= '0;
            if (bit_idx == STOP_LAST) begin
              bit_idx    <= '0;
              Serial_out <= 1'b1;
              state      <= IDLE;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          Serial_out <= 1'b1;
          state      <= IDLE;
        end
      endcase

      // Loading a new word overrides the IDLE / end-of-stop behaviour above.
      // Parity is taken from the whole popped word and the mode is frozen
      // here so later parity_mode changes only affect the next frame.
      if (pop) begin
        shift_reg  <= head;
        par_en     <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
        par_bit    <= (^head) ^ (parity_mode == 2'b10);
        div_cnt    <= '0;
        bit_idx    <= '0;
        Serial_out <= 1'b0;
        state      <= START;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Self-checking bench for uart_tx_fifo. A table of single-word
//            frames plus directed sequences for FIFO fill, back-to-back
//            frames, same-edge push/pop, mid-frame reset and two stop bits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int CPB = 4;

  logic       clk;
  // instance a: one stop bit
  logic       rst_a;
  logic [7:0] tx_data_a;
  logic       tx_valid_a;
  logic       tx_ready_a;
  logic [1:0] parity_mode_a;
  logic       ser_a;
  logic       busy_a;
  logic [2:0] count_a;
  // instance b: two stop bits
  logic       rst_b;
  logic [7:0] tx_data_b;
  logic       tx_valid_b;
  logic       tx_ready_b;
  logic [1:0] parity_mode_b;
  logic       ser_b;
  logic       busy_b;
  logic [2:0] count_b;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .FIFO_DEPTH(4), .CNT_W(3)) dut_a (
    .Clock(clk), .reset_(rst_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .parity_mode(parity_mode_a), .Serial_out(ser_a), .busy(busy_a), .fifo_count(count_a)
  );

  uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .FIFO_DEPTH(4), .CNT_W(3)) dut_b (
    .Clock(clk), .reset_(rst_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .parity_mode(parity_mode_b), .Serial_out(ser_b), .busy(busy_b), .fifo_count(count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [7:0] data;
    logic [1:0] mode;
    bit         par_en;
    bit         par;
    int         frame_cycles;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  // Called in the first cycle of a start bit; checks every cycle of the frame
  // against a slot list built from the word and returns with time in the
  // cycle right after the last stop-bit cycle.
  task automatic expect_frame(input bit inst, input logic [7:0] d, input bit par_en, input bit par,
                              input int stop_bits, output int busy_cycles);
    logic [15:0] slots;
    int n;
    slots = '0;
    n = 0;
    slots[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin
      slots[n] = d[i]; n++;
    end
    if (par_en) begin
      slots[n] = par; n++;
    end
    for (int s = 0; s < stop_bits; s++) begin
      slots[n] = 1'b1; n++;
    end
    busy_cycles = 0;
    for (int s = 0; s < n; s++) begin
      for (int c = 0; c < CPB; c++) begin
        chk($sformatf("frame%0d_w%02h_slot%0d_cyc%0d", inst, d, s, c), inst ? ser_b : ser_a, slots[s]);
        if (inst ? busy_b : busy_a) busy_cycles++;
        tick();
      end
    end
  endtask

  // Holds tx_valid across n consecutive words while a parallel checker
  // follows the serial line frame by frame with no gaps allowed.
  task automatic stream(input int n, input logic [7:0] base);
    fork
      begin : pusher
        int  idx;
        int  guard;
        logic acc;
        idx = 0;
        guard = 0;
        tx_data_a  = base;
        tx_valid_a = 1'b1;
        while (idx < n && guard < 3000) begin
          acc = tx_ready_a;
          tick();
          guard++;
          if (acc) begin
            idx++;
            if (idx == 5) begin
              chk("stream_full_count", count_a, 4);
              chk("stream_full_ready", tx_ready_a, 0);
            end
            tx_data_a = 8'(int'(base) + idx);
          end
        end
        tx_valid_a = 1'b0;
        chk("stream_all_accepted", idx, n);
      end
      begin : watcher
        int g;
        int bc;
        g = 0;
        while (ser_a && g < 20) begin
          tick();
          g++;
        end
        chk("stream_first_start_seen", ser_a, 0);
        for (int k = 0; k < n; k++) begin
          expect_frame(1'b0, 8'(int'(base) + k), 1'b0, 1'b0, 1, bc);
        end
        chk("stream_idle_after", busy_a, 0);
      end
    join
  endtask

  initial begin
    int bc;
    int guard;
    int lows;

    vecs[0] = '{8'h03, 2'b00, 1'b0, 1'b0, 40};
    vecs[1] = '{8'h07, 2'b01, 1'b1, 1'b1, 44};
    vecs[2] = '{8'h07, 2'b10, 1'b1, 1'b0, 44};
    vecs[3] = '{8'h07, 2'b11, 1'b0, 1'b0, 40};
    vecs[4] = '{8'hA5, 2'b01, 1'b1, 1'b0, 44};
    vecs[5] = '{8'hA5, 2'b10, 1'b1, 1'b1, 44};
    vecs[6] = '{8'hFF, 2'b00, 1'b0, 1'b0, 40};
    vecs[7] = '{8'h80, 2'b10, 1'b1, 1'b0, 44};

    rst_a = 1'b1; tx_data_a = '0; tx_valid_a = 1'b0; parity_mode_a = 2'b00;
    rst_b = 1'b1; tx_data_b = '0; tx_valid_b = 1'b0; parity_mode_b = 2'b00;
    tick();
    tick();
    chk("reset_serial_a", ser_a, 1);
    chk("reset_busy_a", busy_a, 0);
    chk("reset_count_a", count_a, 0);
    chk("reset_ready_a", tx_ready_a, 1);
    chk("reset_serial_b", ser_b, 1);
    chk("reset_busy_b", busy_b, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();

    // Table: one word per frame, tx_valid presented in the cycle after edge
    // N, captured at N+1, start bit visible after N+2
    for (int i = 0; i < 8; i++) begin
      tx_data_a     = vecs[i].data;
      parity_mode_a = vecs[i].mode;
      tx_valid_a    = 1'b1;
      tick();
      tx_valid_a = 1'b0;
      chk($sformatf("v%0d_lat_serial_high", i), ser_a, 1);
      chk($sformatf("v%0d_lat_count", i), count_a, 1);
      chk($sformatf("v%0d_lat_busy_low", i), busy_a, 0);
      tick();
      chk($sformatf("v%0d_start_busy", i), busy_a, 1);
      chk($sformatf("v%0d_start_count", i), count_a, 0);
      parity_mode_a = ~vecs[i].mode;
      expect_frame(1'b0, vecs[i].data, vecs[i].par_en, vecs[i].par, 1, bc);
      guard = 0;
      while (busy_a && guard < 100) begin
        bc++;
        guard++;
        tick();
      end
      chk($sformatf("v%0d_frame_cycles", i), bc, vecs[i].frame_cycles);
      chk($sformatf("v%0d_idle_line", i), ser_a, 1);
    end

    // Six words held on tx_valid, FIFO fills, all frames back to back
    parity_mode_a = 2'b00;
    stream(6, 8'hA0);

    // Push lands on the same edge that ends a stop bit with two words queued
    fork
      begin
        tx_data_a = 8'h61; tx_valid_a = 1'b1;
        tick();
        tx_data_a = 8'h62;
        tick();
        tx_data_a = 8'h63;
        tick();
        tx_valid_a = 1'b0;
        chk("same_edge_count_before", count_a, 2);
        for (int k = 0; k < 38; k++) tick();
        chk("same_edge_pre_count", count_a, 2);
        chk("same_edge_pre_line", ser_a, 1);
        tx_data_a = 8'h64; tx_valid_a = 1'b1;
        tick();
        tx_valid_a = 1'b0;
        chk("same_edge_post_count", count_a, 2);
      end
      begin
        int g;
        int b2;
        g = 0;
        while (ser_a && g < 20) begin
          tick();
          g++;
        end
        for (int k = 0; k < 4; k++) begin
          expect_frame(1'b0, 8'(8'h61 + k), 1'b0, 1'b0, 1, b2);
        end
        chk("same_edge_idle_after", busy_a, 0);
      end
    join

    // Pointer wrap: 3*FIFO_DEPTH words in order
    stream(12, 8'h30);

    // Reset during data bit 3 with two words queued
    tx_data_a = 8'hF7; tx_valid_a = 1'b1;
    tick();
    tx_data_a = 8'h11;
    tick();
    tx_data_a = 8'h22;
    tick();
    tx_valid_a = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    chk("rst_pre_busy", busy_a, 1);
    chk("rst_pre_bit3", ser_a, 0);
    chk("rst_pre_count", count_a, 2);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    chk("rst_post_serial", ser_a, 1);
    chk("rst_post_busy", busy_a, 0);
    chk("rst_post_count", count_a, 0);
    chk("rst_post_ready", tx_ready_a, 1);
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      if (!ser_a || busy_a) lows++;
      tick();
    end
    chk("rst_no_further_frame", lows, 0);

    // Two stop bits on instance b, back-to-back frames
    fork
      begin
        tx_data_b = 8'h5A; tx_valid_b = 1'b1;
        tick();
        tx_data_b = 8'hC3;
        tick();
        tx_valid_b = 1'b0;
      end
      begin
        int g;
        int b3;
        g = 0;
        while (ser_b && g < 20) begin
          tick();
          g++;
        end
        chk("stop2_start_seen", ser_b, 0);
        expect_frame(1'b1, 8'h5A, 1'b0, 1'b0, 2, b3);
        chk("stop2_frame0_busy_cycles", b3, 44);
        expect_frame(1'b1, 8'hC3, 1'b0, 1'b0, 2, b3);
        chk("stop2_idle_after", busy_b, 0);
        chk("stop2_line_high", ser_b, 1);
      end
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
